// File: rtl/scope_pkg.sv
// Shared constants and types for the scope measurement path.
// Holds the sample width default, clock rate and Schmitt state enum.
package scope_pkg;

    localparam int DATA_W = 12;
    localparam int CLK_HZ = 100_000_000;

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2
    } schmitt_state_e;

endpackage

// File: rtl/schmitt_edge_detect.sv
// Hysteresis comparator that emits a one-cycle registered pulse
// on each rising crossing of the sample stream through thr.
// Ports: clk, rst_n, sample_valid, sample, thr -> edge_pulse.
module schmitt_edge_detect #(
    parameter int DATA_W = 12,
    parameter int HYST   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] thr,
    output logic              edge_pulse
);
    import scope_pkg::*;

    localparam logic [DATA_W:0] HYST_W = (DATA_W + 1)'(HYST);
    localparam logic [DATA_W:0] MAX_W  = {1'b0, {DATA_W{1'b1}}};

    schmitt_state_e state_q, state_d;
    logic           edge_q, edge_d;

    logic [DATA_W:0] thr_w;
    logic [DATA_W:0] samp_w;
    logic [DATA_W:0] lo_w, hi_w;
    logic [DATA_W:0] lo_c, hi_c;

    // Levels are formed one bit wider so the clamp sees the
    // underflow / overflow instead of a wrapped value.
    always_comb begin
        thr_w  = {1'b0, thr};
        samp_w = {1'b0, sample};
        lo_w   = thr_w - HYST_W;
        hi_w   = thr_w + HYST_W;
        lo_c   = (thr_w < HYST_W) ? '0 : lo_w;
        hi_c   = (hi_w > MAX_W) ? MAX_W : hi_w;
    end

    always_comb begin
        state_d = state_q;
        edge_d  = 1'b0;
        if (sample_valid) begin
            unique case (state_q)
                SEEK: begin
                    if (samp_w <= lo_c) state_d = ARMED;
                end
                ARMED: begin
                    if (samp_w >= hi_c) begin
                        state_d = HIGH;
                        edge_d  = 1'b1;
                    end
                end
                HIGH: begin
                    if (samp_w <= lo_c) state_d = ARMED;
                end
                default: state_d = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEEK;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
        end
    end

    assign edge_pulse = edge_q;

endmodule

// File: rtl/freq_meter.sv
// Gated-count frequency meter: counts Schmitt rising crossings over
// a fixed gate and publishes the count with a valid pulse.
// Ports: clk, rst_n, sample_valid, sample, threshold ->
//        freq_out, freq_valid, overflow.
module freq_meter #(
    parameter int DATA_W      = scope_pkg::DATA_W,
    parameter int GATE_CYCLES = 100_000_000,
    parameter int HYST        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] threshold,
    output logic [31:0]       freq_out,
    output logic              freq_valid,
    output logic              overflow
);
    import scope_pkg::*;

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    logic [GW-1:0]     gate_cnt_q, gate_cnt_d;
    logic [31:0]       edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic [DATA_W-1:0] thr_l_q, thr_l_d;
    logic [31:0]       freq_out_q, freq_out_d;
    logic              freq_valid_q, freq_valid_d;
    logic              overflow_q, overflow_d;

    logic              gate_last;
    logic              gate_start;
    logic [DATA_W-1:0] thr_eff;
    logic              edge_w;
    logic              cnt_max;
    logic [31:0]       cnt_inc;
    logic [31:0]       cnt_next;
    logic              sat_next;

    // On cycle 0 of every gate (incl. right after reset) the live
    // threshold is used and captured; the rest of the gate uses
    // the captured copy.
    always_comb begin
        gate_last  = (gate_cnt_q == LAST);
        gate_start = (gate_cnt_q == '0);
        thr_eff    = gate_start ? threshold : thr_l_q;
    end

    schmitt_edge_detect #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_schmitt (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .thr          (thr_eff),
        .edge_pulse   (edge_w)
    );

    always_comb begin
        cnt_max  = &edge_cnt_q;
        cnt_inc  = cnt_max ? edge_cnt_q : edge_cnt_q + 32'd1;
        cnt_next = edge_w ? cnt_inc : edge_cnt_q;
        sat_next = sat_q | (edge_w & cnt_max);

        thr_l_d      = thr_eff;
        gate_cnt_d   = gate_last ? '0 : gate_cnt_q + GW'(1);
        edge_cnt_d   = cnt_next;
        sat_d        = sat_next;
        freq_out_d   = freq_out_q;
        overflow_d   = overflow_q;
        freq_valid_d = 1'b0;

        // An edge landing on the last cycle still counts here.
        if (gate_last) begin
            freq_out_d   = cnt_next;
            overflow_d   = sat_next;
            freq_valid_d = 1'b1;
            edge_cnt_d   = '0;
            sat_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            thr_l_q      <= '0;
            freq_out_q   <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            thr_l_q      <= thr_l_d;
            freq_out_q   <= freq_out_d;
            freq_valid_q <= freq_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign freq_out   = freq_out_q;
    assign freq_valid = freq_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 1000-cycle gate.
// Expected counts are worked out by hand from the stimulus phases.
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [11:0] sample;
    logic [11:0] threshold;
    logic [31:0] freq_out;
    logic        freq_valid;
    logic        overflow;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mode   = 0;
    int per    = 100;
    int pa     = -1;
    int pb     = -1;
    int seen   = 0;
    logic [11:0] lv = 12'd0;
    logic [11:0] hv = 12'd4095;

    always #5 clk = ~clk;

    freq_meter #(
        .DATA_W      (12),
        .GATE_CYCLES (1000),
        .HYST        (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .threshold    (threshold),
        .freq_out     (freq_out),
        .freq_valid   (freq_valid),
        .overflow     (overflow)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample presented during cycle cyc (cyc = clocks since release).
    task automatic drive();
        case (mode)
            1: sample = ((cyc % per) < per / 2) ? lv : hv;
            2: sample = (cyc % 2 == 1) ? 12'd2060 : 12'd2040;
            3: begin
                if (cyc % 2 == 1)
                    sample = ((cyc / 2) % 2 == 1) ? 12'd2060 : 12'd2040;
                else
                    sample = ((cyc % 50) < 25) ? 12'd0 : 12'd4095;
            end
            4: sample = (cyc == pa || cyc == pb) ? 12'd4095 : 12'd0;
            default: sample = 12'd0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            tick();
        end
    endtask

    task automatic gate_chk(input string tag, input int exp);
        chk({tag, "_fv"}, {31'd0, freq_valid}, 32'd1);
        chk(tag, freq_out, 32'(exp));
        chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b1;
        sample       = 12'd0;
        threshold    = 12'd2048;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_freq", freq_out, 32'd0);
        chk("rst_fv", {31'd0, freq_valid}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        run(999);
        chk("fv_cyc999", {31'd0, freq_valid}, 32'd0);
        run(1);
        gate_chk("idle", 0);
        run(1);
        chk("fv_one_cycle", {31'd0, freq_valid}, 32'd0);
        chk("hold_idle", freq_out, 32'd0);
        run(999);
        gate_chk("idle2", 0);

        mode = 1;
        run(1000);
        gate_chk("sq100_a", 10);
        run(500);
        chk("hold_mid", freq_out, 32'd10);
        run(500);
        gate_chk("sq100_b", 10);

        mode = 2;
        run(1000);
        gate_chk("noise", 0);
        mode = 3;
        run(1000);
        gate_chk("noise_sq50", 20);

        mode = 4;
        pa   = 6998;
        pb   = 7999;
        run(1000);
        gate_chk("edge_c998", 1);
        run(1000);
        gate_chk("edge_c999", 0);
        run(100);
        sample_valid = 1'b0;
        pa = 8500;
        run(900);
        sample_valid = 1'b1;
        gate_chk("edge_c999_next", 1);

        mode      = 1;
        per       = 10;
        lv        = 12'd0;
        hv        = 12'd100;
        threshold = 12'd5;
        run(1000);
        gate_chk("clamp_lo", 100);
        run(500);
        threshold = 12'd2048;
        run(500);
        gate_chk("thr_midgate", 100);
        run(1000);
        gate_chk("thr_next", 0);

        threshold = 12'd4090;
        hv        = 12'd4095;
        run(1000);
        gate_chk("clamp_hi", 100);

        threshold = 12'd2048;
        per       = 100;
        run(500);
        chk("pre_rst_hold", freq_out, 32'd100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_freq", freq_out, 32'd0);
        chk("mid_rst_fv", {31'd0, freq_valid}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        seen  = 0;
        for (int i = 0; i < 999; i++) begin
            drive();
            tick();
            if (freq_valid) seen++;
        end
        chk("no_fv_after_rst", 32'(seen), 32'd0);
        run(1);
        gate_chk("post_rst", 10);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
